// File: rtl/dvp_capture_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dvp_capture_ctrl_if : DVP sensor bus in, packed pixel stream out       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dvp_capture_ctrl_if;
  logic        cmos_vsync_i;
  logic        cmos_href_i;
  logic [7:0]  cmos_d_i;
  logic [15:0] pix_data_o;
  logic        pix_valid_o;
  logic        sof_o;
  logic        sol_o;
  logic        eof_o;

  modport slave (
    input  cmos_vsync_i, cmos_href_i, cmos_d_i,
    output pix_data_o, pix_valid_o, sof_o, sol_o, eof_o
  );

  modport master (
    output cmos_vsync_i, cmos_href_i, cmos_d_i,
    input  pix_data_o, pix_valid_o, sof_o, sol_o, eof_o
  );
endinterface
`default_nettype wire

// File: rtl/dvp_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dvp_capture_ctrl : DVP camera frame capture, byte pairs -> 16b pixels  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dvp_capture_ctrl #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int SKIP_FRAMES = 2
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  input  wire logic         start_i,
  input  wire logic         stop_i,
  input  wire logic         cont_i,
  dvp_capture_ctrl_if.slave bus,
  output logic              busy_o,
  output logic [11:0]       line_cnt_o,
  output logic              err_len_o,
  output logic              err_lines_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_SKIP    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam logic [11:0] C_H_ACTIVE  = 12'(H_ACTIVE);
  localparam logic [11:0] C_V_ACTIVE  = 12'(V_ACTIVE);
  localparam logic [3:0]  C_SKIP_LOAD = 4'(SKIP_FRAMES - 1);
  localparam bit          C_NO_SKIP   = (SKIP_FRAMES == 0);

  state_t      r_state;
  logic        r_vs_d, r_href_d;
  logic        r_cont, r_stop_pend;
  logic [3:0]  r_skip_cnt;
  logic        r_phase, r_in_line, r_sof_pend;
  logic [7:0]  r_hi;
  logic [11:0] r_pix_cnt, r_line_cnt;
  logic [15:0] r_pix_data;
  logic        r_pix_valid, r_sof, r_sol;
  logic        r_err_len, r_err_lines;

  logic        w_vs_rise, w_href_rise, w_href_fall, w_line_done;
  logic        w_frame_end, w_lines_bad, w_len_bad, w_enter_capture;
  logic [11:0] w_line_inc, w_pix_inc, w_lines_eff;

  assign w_vs_rise   = bus.cmos_vsync_i & ~r_vs_d;
  assign w_href_rise = bus.cmos_href_i & ~r_href_d;
  assign w_href_fall = ~bus.cmos_href_i & r_href_d;
  assign w_line_done = w_href_fall & r_in_line;
  assign w_line_inc  = (r_line_cnt == 12'hFFF) ? r_line_cnt : r_line_cnt + 12'd1;
  assign w_pix_inc   = (r_pix_cnt == 12'hFFF) ? r_pix_cnt : r_pix_cnt + 12'd1;
  assign w_frame_end = (r_state == ST_CAPTURE) & w_vs_rise;
  // A line that closes on the very cycle vsync rises still belongs to this frame
  assign w_lines_eff = w_line_done ? w_line_inc : r_line_cnt;
  assign w_lines_bad = (w_lines_eff != C_V_ACTIVE);
  assign w_len_bad   = (r_pix_cnt != C_H_ACTIVE) | r_phase;

  assign w_enter_capture = ~stop_i & w_vs_rise &
                           (((r_state == ST_WAIT_VS) & C_NO_SKIP) |
                            ((r_state == ST_SKIP) & (r_skip_cnt == 4'd0)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_vs_d      <= 1'b0;
      r_href_d    <= 1'b0;
      r_cont      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_skip_cnt  <= 4'd0;
      r_phase     <= 1'b0;
      r_in_line   <= 1'b0;
      r_sof_pend  <= 1'b0;
      r_hi        <= 8'd0;
      r_pix_cnt   <= 12'd0;
      r_line_cnt  <= 12'd0;
      r_pix_data  <= 16'd0;
      r_pix_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_sol       <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_lines <= 1'b0;
    end else begin
      r_vs_d      <= bus.cmos_vsync_i;
      r_href_d    <= bus.cmos_href_i;
      r_pix_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_sol       <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state     <= ST_WAIT_VS;
            r_cont      <= cont_i;
            r_err_len   <= 1'b0;
            r_err_lines <= 1'b0;
            r_stop_pend <= 1'b0;
          end
        end

        ST_WAIT_VS: begin
          if (stop_i) begin
            r_state <= ST_IDLE;
          end else if (w_vs_rise && !C_NO_SKIP) begin
            r_state    <= ST_SKIP;
            r_skip_cnt <= C_SKIP_LOAD;
          end
        end

        ST_SKIP: begin
          if (stop_i) begin
            r_state <= ST_IDLE;
          end else if (w_vs_rise && r_skip_cnt != 4'd0) begin
            r_skip_cnt <= r_skip_cnt - 4'd1;
          end
        end

        ST_CAPTURE: begin
          if (stop_i) r_stop_pend <= 1'b1;

          if (w_frame_end) begin
            if ((w_line_done && w_len_bad) || bus.cmos_href_i) r_err_len <= 1'b1;
            if (w_lines_bad) r_err_lines <= 1'b1;
            r_line_cnt <= 12'd0;
            r_in_line  <= 1'b0;
            r_phase    <= 1'b0;
            if (r_cont && !(r_stop_pend || stop_i)) begin
              r_sof_pend <= 1'b1;
            end else begin
              r_state     <= ST_IDLE;
              r_stop_pend <= 1'b0;
            end
          end else if (w_href_rise) begin
            r_in_line <= 1'b1;
            r_pix_cnt <= 12'd0;
            r_hi      <= bus.cmos_d_i;
            r_phase   <= 1'b1;
          end else if (bus.cmos_href_i && r_in_line) begin
            if (!r_phase) begin
              r_hi    <= bus.cmos_d_i;
              r_phase <= 1'b1;
            end else begin
              r_pix_data  <= {r_hi, bus.cmos_d_i};
              r_pix_valid <= 1'b1;
              r_sol       <= (r_pix_cnt == 12'd0);
              r_sof       <= (r_pix_cnt == 12'd0) & r_sof_pend;
              if (r_pix_cnt == 12'd0) r_sof_pend <= 1'b0;
              r_pix_cnt   <= w_pix_inc;
              r_phase     <= 1'b0;
            end
          end else if (w_line_done) begin
            r_line_cnt <= w_line_inc;
            if (w_len_bad) r_err_len <= 1'b1;
            r_in_line  <= 1'b0;
            r_phase    <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase

      if (w_enter_capture) begin
        r_state     <= ST_CAPTURE;
        r_sof_pend  <= 1'b1;
        r_line_cnt  <= 12'd0;
        r_in_line   <= 1'b0;
        r_phase     <= 1'b0;
        r_stop_pend <= 1'b0;
      end
    end
  end

  // End-of-frame flags are decoded from the live vsync edge so they line up with it
  assign bus.eof_o       = w_frame_end & ~rst_i;
  assign err_lines_o     = r_err_lines | (w_frame_end & w_lines_bad & ~rst_i);
  assign bus.pix_data_o  = r_pix_data;
  assign bus.pix_valid_o = r_pix_valid;
  assign bus.sof_o       = r_sof;
  assign bus.sol_o       = r_sol;
  assign busy_o          = (r_state != ST_IDLE);
  assign line_cnt_o      = r_line_cnt;
  assign err_len_o       = r_err_len;

endmodule
`default_nettype wire

// File: doc/dvp_capture_ctrl.md
DVP_CAPTURE_CTRL -- requirements
Module: dvp_capture_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280: expected pixels (16-bit) per line.
REQ-002 SHALL have parameter V_ACTIVE, default 720: expected lines per frame.
REQ-003 SHALL have parameter SKIP_FRAMES, default 2: frames discarded after start, range 0-15.
REQ-004 SHALL have port clk_i  in  1: sensor pixel clock; the single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1: synchronous, active-high reset.
REQ-006 SHALL have port start_i  in  1: one-cycle capture request.
REQ-007 SHALL have port stop_i  in  1: one-cycle request to end after the current frame.
REQ-008 SHALL have port cont_i  in  1: 1 = continuous frames, 0 = single frame; sampled when start is accepted.
REQ-009 SHALL have port cmos_vsync_i  in  1: frame sync; a rising edge marks frame boundary.
REQ-010 SHALL have port cmos_href_i  in  1: line valid.
REQ-011 SHALL have port cmos_d_i  in  8: sensor byte bus.
REQ-012 SHALL have port pix_data_o  out  16: packed pixel, first byte in [15:8].
REQ-013 SHALL have port pix_valid_o  out  1: pix_data_o valid, one cycle per pixel.
REQ-014 SHALL have ports sof_o, sol_o, eof_o  out  1 each: start-of-frame, start-of-line, end-of-frame pulses.
REQ-015 SHALL have port busy_o  out  1: high in any state except IDLE.
REQ-016 SHALL have port line_cnt_o  out  12: lines completed in the current frame.
REQ-017 SHALL have ports err_len_o, err_lines_o  out  1 each: sticky line-length and line-count errors.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_VS, SKIP, CAPTURE.
REQ-019 SHALL detect vsync rising edge (vs_rise) from a one-cycle-delayed copy of cmos_vsync_i.
REQ-020 IDLE: start_i -> WAIT_VS; latch cont_i; clear err_len_o, err_lines_o; stop_i in the same cycle SHALL be ignored.
REQ-021 WAIT_VS: on vs_rise -> SKIP when SKIP_FRAMES>0 (skip counter loaded SKIP_FRAMES-1), else -> CAPTURE.
REQ-022 SKIP: on vs_rise decrement; at 0 with vs_rise -> CAPTURE; no pix_valid_o in SKIP.
REQ-023 start_i SHALL be ignored outside IDLE.
REQ-024 CAPTURE: byte phase resets to 0 on each href rising; per href-high cycle: phase 0 latches byte into [15:8], phase 1 forms pixel, pix_valid_o high the next cycle (latency 1 cycle from second byte).
REQ-025 Pixel counter (12 bit) SHALL clear at href rising and increment per pix_valid_o.
REQ-026 sol_o SHALL coincide with first pix_valid_o of each line; sof_o additionally with the first of the frame.
REQ-027 At href falling in CAPTURE: line_cnt_o increments; if pixel count != H_ACTIVE or phase is 1 (odd bytes) then err_len_o set; a dangling odd byte SHALL be discarded.
REQ-028 vs_rise in CAPTURE SHALL end the frame: eof_o pulse same cycle; err_lines_o set if line_cnt_o != V_ACTIVE; line_cnt_o cleared next cycle.
REQ-029 After frame end: if cont latched and no stop pending, remain CAPTURE (new frame begins); else -> IDLE.
REQ-030 stop_i in WAIT_VS or SKIP SHALL go IDLE next cycle; in CAPTURE it SHALL set stop pending, honoured at next vs_rise.
REQ-031 vs_rise while href high SHALL end the frame; that partial line SHALL not count and SHALL set err_len_o.
REQ-032 Counters SHALL saturate at 4095, never wrap.

Reset
REQ-033 On rst_i: state IDLE; pix_data_o=0; pix_valid_o, sof_o, sol_o, eof_o, busy_o, err_len_o, err_lines_o=0; line_cnt_o=0; stop pending, phase, counters cleared; applies mid-frame with no eof_o.

Verification
REQ-034 H_ACTIVE=4, V_ACTIVE=2, SKIP_FRAMES=1, cont=0; start, 3 frames of bytes 0x01..0x08 per line -> frame 1 skipped; frame 2 yields pixels 0x0102,0x0304,0x0506,0x0708 per line, sof_o on first, eof_o at next vs_rise, IDLE, no errors.
REQ-035 cont=1, stop_i mid-frame 2 of capture -> frame 2 completes with eof_o, then IDLE, busy_o=0.
REQ-036 Line with 7 bytes -> 3 pixels, err_len_o=1, sticky until next accepted start.
REQ-037 Frame of 3 lines with V_ACTIVE=2 -> err_lines_o=1 at eof_o; line_cnt_o reads 3 before clear.
REQ-038 rst_i asserted mid-line in CAPTURE -> next cycle all outputs 0, IDLE; subsequent frames produce no pix_valid_o until start.
REQ-039 start_i and stop_i together in IDLE -> WAIT_VS entered, busy_o=1.
